axi_wr_burst_slave: RTL
=======================

AXI_WR_BURST_SLAVE -- requirements
Module: axi_wr_burst_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 256, write data width in bits; legal values 32..1024, power of two.
REQ-002 Parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 Parameter STRB_WIDTH, default DATA_WIDTH/8, derived, not overridden.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 awvalid in 1, awaddr in ADDR_WIDTH, awlen in 8, awsize in 3, awburst in 2, awready out 1: write-address channel.
REQ-007 wvalid in 1, wdata in DATA_WIDTH, wstrb in STRB_WIDTH, wlast in 1, wready out 1: write-data channel.
REQ-008 bvalid out 1, bresp out 2, bready in 1: write-response channel.
REQ-009 mem_we out 1, mem_addr out ADDR_WIDTH, mem_wdata out DATA_WIDTH, mem_be out STRB_WIDTH: registered memory write port, no backpressure.

Function
REQ-010 FSM states: IDLE, DATA, RESP; one burst outstanding at a time.
REQ-011 IDLE: awready=1, wready=0; awvalid high latches addr/len/size/burst, clears error flag, beat counter=0, moves to DATA next cycle.
REQ-012 DATA: awready=0, wready=1; each wvalid&wready beat increments beat counter and advances address.
REQ-013 Beat (awlen+1) is the final beat regardless of wlast; FSM moves to RESP the cycle after it.
REQ-014 Accepted beat drives mem_we=1 next cycle with that beat's address, wdata, and wstrb as mem_be; write latency exactly 1 cycle.
REQ-015 Address step = 1<<awsize bytes; FIXED (0): address constant; INCR (1): add step; WRAP (2): add step, wrap at aligned boundary of (awlen+1)*step bytes.
REQ-016 INCR address arithmetic modulo 2^ADDR_WIDTH; no 4 KB boundary check.
REQ-017 Error conditions, latched at AW accept: awburst=3; awsize > log2(STRB_WIDTH); WRAP with awlen not in {1,3,7,15}; WRAP with awaddr not step-aligned.
REQ-018 Error during data: wlast=1 on a non-final beat, or wlast=0 on the final beat.
REQ-019 AW-time error: all beats still accepted, mem_we held 0 for the whole burst.
REQ-020 Data-time wlast error: writes still performed; only the response is affected.
REQ-021 RESP: bvalid=1, bresp=2'b10 (SLVERR) if any error flag set, else 2'b00 (OKAY); bvalid and bresp stable until bready; bvalid&bready returns FSM to IDLE next cycle.
REQ-022 awvalid during DATA or RESP is not accepted (awready=0); wvalid during IDLE or RESP is not accepted (wready=0).
REQ-023 awready and wready are combinational decodes of the state register only; no combinational path from any input.

Reset
REQ-024 rst forces IDLE, awready=1 after release, wready=0, bvalid=0, bresp=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, beat counter=0, error flag=0.
REQ-025 rst mid-burst discards the burst; no response is issued for it; the pending mem_we is dropped.

Structure
REQ-026 Package axi_wr_pkg holds burst constants (FIXED/INCR/WRAP), response constants (OKAY/SLVERR), the state enum, and the WRAP legal-length check function.
REQ-027 Sub-module axi_addr_gen (combinational) computes the next address from the current address, size, len and burst.

Verification
REQ-028 INCR: awaddr=0x1000, awlen=3, awsize=5 -> mem_addr 0x1000, 0x1020, 0x1040, 0x1060 on 4 consecutive cycles; bresp=OKAY.
REQ-029 WRAP: awaddr=0x1060, awlen=3, awsize=5 -> mem_addr 0x1060, 0x1000, 0x1020, 0x1040; bresp=OKAY.
REQ-030 awsize=6 with DATA_WIDTH=256, awlen=1 -> 2 beats accepted, mem_we never asserted, bresp=SLVERR.
REQ-031 wlast=1 on beat 2 of awlen=3 -> 4 writes performed, bresp=SLVERR; bready held low 5 cycles -> bvalid/bresp stable throughout.
REQ-032 FIXED with wvalid gaps: awaddr=0x200, awlen=2, beats gapped by idle cycles -> 3 writes to 0x200 with matching mem_be.
REQ-033 rst pulsed after beat 1 of awlen=7 -> all outputs at reset values, no bvalid; the following INCR burst completes with OKAY.

Source files
------------

// File: rtl/axi_wr_pkg.sv
// Shared AXI write-path constants, FSM state encoding and WRAP length legality check.
package axi_wr_pkg;

   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_RESP
   } state_t;

   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Next-beat byte address for FIXED/INCR/WRAP bursts; purely combinational, no flow control.
import axi_wr_pkg::*;

module axi_addr_gen #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [2:0]            size,
   input  logic [7:0]            len,
   input  logic [1:0]            burst,
   output logic [ADDR_WIDTH-1:0] next_addr
);

   logic [ADDR_WIDTH-1:0] step;
   logic [ADDR_WIDTH-1:0] incr;
   logic [ADDR_WIDTH-1:0] wrap_mask;

   always_comb begin
      step      = ADDR_WIDTH'(1) << size;
      incr      = addr + step;
      // WRAP container is (len+1)*step bytes; legal lengths make it a power of two
      wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_INCR:  next_addr = incr;
         BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
         default:     next_addr = incr;
      endcase
   end

endmodule

// File: rtl/axi_wr_burst_slave.sv
// AXI write burst slave, one burst in flight: AW -> W beats -> B; each beat reaches the memory port 1 cycle later.
// awready/wready decode the state register only; bvalid/bresp hold until bready; memory port has no backpressure.
import axi_wr_pkg::*;

module axi_wr_burst_slave #(
   parameter  int DATA_WIDTH = 256,
   parameter  int ADDR_WIDTH = 32,
   localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  awvalid,
   input  logic [ADDR_WIDTH-1:0] awaddr,
   input  logic [7:0]            awlen,
   input  logic [2:0]            awsize,
   input  logic [1:0]            awburst,
   output logic                  awready,
   input  logic                  wvalid,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [STRB_WIDTH-1:0] wstrb,
   input  logic                  wlast,
   output logic                  wready,
   output logic                  bvalid,
   output logic [1:0]            bresp,
   input  logic                  bready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [STRB_WIDTH-1:0] mem_be
);

   localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_WIDTH));

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
   logic [7:0]            len_q;
   logic [2:0]            size_q;
   logic [1:0]            burst_q;
   logic [7:0]            beat_cnt;
   logic                  aw_err;
   logic                  w_err;
   logic                  aw_hs;
   logic                  w_hs;
   logic                  last_beat;
   logic                  aw_err_c;
   logic [ADDR_WIDTH-1:0] align_mask;

   assign aw_hs     = awvalid & awready;
   assign w_hs      = wvalid & wready;
   assign last_beat = (beat_cnt == len_q);

   always_comb begin
      align_mask = (ADDR_WIDTH'(1) << awsize) - ADDR_WIDTH'(1);
      aw_err_c   = (awburst == 2'd3) || (awsize > MAX_SIZE) ||
                   ((awburst == BURST_WRAP) && !wrap_len_ok(awlen)) ||
                   ((awburst == BURST_WRAP) && ((awaddr & align_mask) != '0));
   end

   axi_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .addr      (addr_q),
      .size      (size_q),
      .len       (len_q),
      .burst     (burst_q),
      .next_addr (addr_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      awready   = 1'b0;
      wready    = 1'b0;
      bvalid    = 1'b0;
      case (state)
         ST_IDLE: begin
            awready = 1'b1;
            if (awvalid) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            wready = 1'b1;
            // beat count, not wlast, terminates the burst
            if (wvalid && last_beat) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            bvalid = 1'b1;
            if (bready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign bresp = (bvalid && (aw_err || w_err)) ? RESP_SLVERR : RESP_OKAY;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         beat_cnt  <= '0;
         aw_err    <= 1'b0;
         w_err     <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
      end else begin
         mem_we <= 1'b0;
         if (aw_hs) begin
            addr_q   <= awaddr;
            len_q    <= awlen;
            size_q   <= awsize;
            burst_q  <= awburst;
            beat_cnt <= '0;
            aw_err   <= aw_err_c;
            w_err    <= 1'b0;
         end
         if (w_hs) begin
            // malformed bursts are drained but never reach memory
            mem_we    <= ~aw_err;
            mem_addr  <= addr_q;
            mem_wdata <= wdata;
            mem_be    <= wstrb;
            addr_q    <= addr_nxt;
            beat_cnt  <= beat_cnt + 8'd1;
            if (wlast != last_beat) w_err <= 1'b1;
         end
      end
   end

endmodule
